booth_bitpair_mul: RTL and testbench

- Sequential signed 32x32 multiplier for the MiniSRC ALU MUL instruction.
- Uses radix-4 (bit-pair) Booth recoding; 16 add/shift steps produce a 64-bit product for the HI/LO registers.
- Sits downstream of the 4-bit CLA slice: the add/subtract datapath is a chain of 4-bit CLA groups, with group g/p used for carry lookahead between slices.
- The ALU control unit drives start and waits for done.

---
 rtl/booth_bitpair_mul.sv | 202 ++++++++++++++++++++
 tb/tb_booth_bitpair_mul.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_bitpair_mul.sv
// Sequential signed WIDTHxWIDTH multiplier using radix-4 (bit-pair) Booth recoding.
// One add/shift step per clock through a chain of 4-bit CLA groups; product lands on hi/lo.

module booth_bitpair_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       g_o,
  output logic       p_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c;
  assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_o = &p;
endmodule

module booth_bitpair_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int STEPS = WIDTH / 2;
  localparam int AW    = WIDTH + 2;   // accumulator: room for +/-2M
  localparam int CW    = WIDTH + 4;   // adder width, a whole number of 4-bit groups
  localparam int NG    = CW / 4;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [AW-1:0]      a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Booth recoding of {Q[1],Q[0],Q[-1]} into a magnitude and a subtract flag.
  logic [AW-1:0] m_ext, m2_ext, pp_mag, pp_opnd;
  logic          pp_neg;

  assign m_ext  = {{2{m_q[WIDTH-1]}}, m_q};
  assign m2_ext = {m_q[WIDTH-1], m_q, 1'b0};

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pp_mag = '0;
    pp_neg = 1'b0;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: pp_mag = m_ext;
      3'b011:         pp_mag = m2_ext;
      3'b100: begin
        pp_mag = m2_ext;
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_mag = m_ext;
        pp_neg = 1'b1;
      end
      default: ;
    endcase
  end

  assign pp_opnd = pp_neg ? ~pp_mag : pp_mag;

  // Adder: chained 4-bit CLA groups, group g/p forming the inter-group carries.
  logic [CW-1:0] add_a, add_b, sum;
  logic [NG-1:0] grp_g, grp_p, carry;
  logic          cout_unused;

  assign add_a    = {{2{a_q[AW-1]}}, a_q};
  assign add_b    = {{2{pp_opnd[AW-1]}}, pp_opnd};
  assign carry[0] = pp_neg;

  for (genvar gi = 0; gi < NG; gi++) begin : g_cla
    booth_bitpair_cla4 u_cla4 (
      .a_i (add_a[4*gi +: 4]),
      .b_i (add_b[4*gi +: 4]),
      .c_i (carry[gi]),
      .s_o (sum[4*gi +: 4]),
      .g_o (grp_g[gi]),
      .p_o (grp_p[gi])
    );
    if (gi < NG - 1) begin : g_lookahead
      assign carry[gi+1] = grp_g[gi] | (grp_p[gi] & carry[gi]);
    end
  end

  assign cout_unused = grp_g[NG-1] | (grp_p[NG-1] & carry[NG-1]);

  // The sum is already sign-extended by two bits, so dropping its two low
  // bits is exactly the arithmetic right shift of the accumulator.
  logic [AW-1:0]    a_step;
  logic [WIDTH-1:0] q_step;
  logic             qm1_step;

  assign a_step   = sum[CW-1:2];
  assign q_step   = {sum[1:0], q_q[WIDTH-1:2]};
  assign qm1_step = q_q[1];

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // The edge leaving DONE also serves as the first IDLE sample.
        state_d = S_IDLE;
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_step;
        q_d   = q_step;
        qm1_d = qm1_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
          hi_d    = a_step[WIDTH-1:0];
          lo_d    = q_step;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the operand and accumulator registers are reset as well, so an aborted operation leaves no trace.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_booth_bitpair_mul.sv
// Self-checking bench for booth_bitpair_mul: directed corners, start-handling cases,
// mid-run reset and randomized signed pairs against a plain 64-bit multiply.

module tb_booth_bitpair_mul;
  localparam int W        = 32;
  localparam int LATENCY  = 16;
  localparam int MAX_WAIT = 40;
  localparam int N_RANDOM = 2000;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_bitpair_mul #(.WIDTH(W)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  function automatic logic [63:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q);
    longint p;
    p = longint'(signed'(m)) * longint'(signed'(q));
    return 64'(p);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, scramble the operand inputs while it runs, and
  // check busy, latency, product and the single-cycle done pulse.
  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input string tag);
    int lat;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    step();
    start = 1'b0;
    check({tag, ".busy_run"}, 64'(busy), 64'd1);
    lat = 0;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      multiplicand = $urandom;
      multiplier   = $urandom;
      step();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(LATENCY));
    check({tag, ".product"}, {hi, lo}, ref_prod(m, q));
    check({tag, ".busy_done"}, 64'(busy), 64'd1);
    step();
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    int first_done;
    int second_done;
    logic [63:0] prod1;
    logic [63:0] prod2;

    // Reset: two cycles low, release, three idle cycles.
    clr = 1'b0;
    repeat (2) step();
    clr = 1'b1;
    repeat (3) step();
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);

    // Directed values.
    do_op(32'd7, 32'd6, "m7q6");
    check("m7q6.exact", {hi, lo}, 64'h0000_0000_0000_002A);
    do_op(32'hFFFF_FFFD, 32'd5, "mneg3q5");
    check("mneg3q5.exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mneg1qneg1");
    check("mneg1qneg1.exact", {hi, lo}, 64'h0000_0000_0000_0001);
    do_op(32'h8000_0000, 32'h8000_0000, "minmin");
    check("minmin.exact", {hi, lo}, 64'h4000_0000_0000_0000);
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxmax");
    check("maxmax.exact", {hi, lo}, 64'h3FFF_FFFF_0000_0001);

    // A start pulse at E5 while running is ignored.
    multiplicand = 32'd7;
    multiplier   = 32'd6;
    start        = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      if (lat == 4) begin
        start        = 1'b1;
        multiplicand = 32'h1234_5678;
        multiplier   = 32'h1234_5678;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    check("ignore.latency", 64'(lat), 64'(LATENCY));
    check("ignore.product", {hi, lo}, 64'd42);
    step();
    check("ignore.no_accept", 64'(busy), 64'd0);

    // Start held high: accepts at E0 and E17, done at E16 and E33.
    multiplicand = 32'd3;
    multiplier   = 32'd4;
    start        = 1'b1;
    step();
    first_done  = -1;
    second_done = -1;
    prod1       = '0;
    prod2       = '0;
    for (int k = 1; k <= 2 * MAX_WAIT && second_done < 0; k++) begin
      step();
      if (done === 1'b1) begin
        if (first_done < 0) begin
          first_done   = k;
          prod1        = {hi, lo};
          multiplicand = 32'd5;
          multiplier   = 32'hFFFF_FFF7;
        end else begin
          second_done = k;
          prod2       = {hi, lo};
          start       = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("held.first_done", 64'(first_done), 64'd16);
    check("held.second_done", 64'(second_done), 64'd33);
    check("held.prod1", prod1, 64'd12);
    check("held.prod2", prod2, ref_prod(32'd5, 32'hFFFF_FFF7));
    step();
    check("held.idle", 64'(busy), 64'd0);

    // Reset asserted mid-RUN at count 7 discards the operation.
    do_op(32'h0001_0003, 32'h0000_0205, "pre_reset");
    multiplicand = 32'h7FFF_FFFF;
    multiplier   = 32'h7FFF_FFFF;
    start        = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    clr = 1'b0;
    #1;
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.hi", 64'(hi), 64'd0);
    check("midrst.lo", 64'(lo), 64'd0);
    step();
    clr = 1'b1;
    step();
    check("midrst.still_idle", 64'(busy), 64'd0);
    do_op(32'd11, 32'hFFFF_FFF3, "post_reset");

    // Randomized signed pairs, biased towards the extreme values.
    for (int i = 0; i < N_RANDOM; i++) begin
      do_op(pick_operand(), pick_operand(), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
